// File: rtl/cont_pkg.sv
// cont_pkg: shared state encoding, counter mode constants and default widths for cont_arbiter
package cont_pkg;
  localparam int DW = 4;
  localparam int CW = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic [1:0] MODO_UP  = 2'b00;
  localparam logic [1:0] MODO_DN  = 2'b01;
  localparam logic [1:0] MODO_DN3 = 2'b10;
  localparam logic [1:0] MODO_LD  = 2'b11;
endpackage

// File: rtl/cont_arbiter_if.sv
// cont_arbiter_if: requester, arbiter and shared-counter signal bundle
interface cont_arbiter_if #(parameter int DW = 4, parameter int CW = 4);
  logic [1:0]    req;
  logic [1:0]    req_modo0;
  logic [DW-1:0] req_D0;
  logic [CW-1:0] req_cic0;
  logic [1:0]    req_modo1;
  logic [DW-1:0] req_D1;
  logic [CW-1:0] req_cic1;
  logic [DW-1:0] cnt_Q;
  logic          cnt_RCO;
  logic          cnt_enb;
  logic [1:0]    cnt_modo;
  logic [DW-1:0] cnt_D;
  logic [1:0]    gnt;
  logic          done;
  logic [DW-1:0] res_Q;
  logic          res_rco;
  logic          busy;
  modport master (
    output req, req_modo0, req_D0, req_cic0, req_modo1, req_D1, req_cic1, cnt_Q, cnt_RCO,
    input  cnt_enb, cnt_modo, cnt_D, gnt, done, res_Q, res_rco, busy
  );
  modport slave (
    input  req, req_modo0, req_D0, req_cic0, req_modo1, req_D1, req_cic1, cnt_Q, cnt_RCO,
    output cnt_enb, cnt_modo, cnt_D, gnt, done, res_Q, res_rco, busy
  );
endinterface

// File: rtl/cont_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick, one-hot winner; on contention the requester not served last wins
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);
  assign win = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/cont_arbiter.sv
// cont_arbiter: round-robin sequencer sharing one mode counter between two requesters (optional RCO_STOP_EN ends a run on the first RCO sample)
module cont_arbiter
  import cont_pkg::*;
#(
  parameter int DW = 4,
  parameter int CW = 4
) (
  input logic clk,
  input logic reset,
  cont_arbiter_if.slave bus
);
  state_t state, state_n;
  logic [1:0] win, gnt_r, modo_r, modo_sel;
  logic [DW-1:0] d_r, d_sel, res_q;
  logic [CW-1:0] cnt_r, cic_sel;
  logic last, acc, res_rco, run, held, stop, start;
  rr_pick2 u_pick (.req(bus.req), .last(last), .win(win));
  assign modo_sel = win[1] ? bus.req_modo1 : bus.req_modo0;
  assign d_sel    = win[1] ? bus.req_D1 : bus.req_D0;
  assign cic_sel  = win[1] ? bus.req_cic1 : bus.req_cic0;
  assign run      = state == RUN;
  assign start    = state == IDLE && |win;
  assign held     = |(bus.req & gnt_r);
`ifdef RCO_STOP_EN
  assign stop = bus.cnt_RCO;
`else
  assign stop = 1'b0;
`endif
  assign bus.cnt_enb  = run;
  assign bus.cnt_modo = run ? modo_r : MODO_UP;
  assign bus.cnt_D    = run ? d_r : '0;
  assign bus.gnt      = gnt_r;
  assign bus.done     = state == DONE;
  assign bus.busy     = state != IDLE;
  assign bus.res_Q    = res_q;
  assign bus.res_rco  = res_rco;
  // next state: grant from IDLE, run down the count (or abort / early stop), DONE always returns to IDLE
  always_comb begin
    state_n = IDLE;
    if (start) state_n = cic_sel == '0 ? DONE : RUN;
    else if (run && held) state_n = (cnt_r == CW'(1) || stop) ? DONE : RUN;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // grant, latched request, remaining count, RCO accumulation and results
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_r   <= '0;
      last    <= 1'b1;
      modo_r  <= MODO_UP;
      d_r     <= '0;
      cnt_r   <= '0;
      acc     <= 1'b0;
      res_q   <= '0;
      res_rco <= 1'b0;
    end else begin
      if (start) begin
        gnt_r  <= win;
        modo_r <= modo_sel;
        d_r    <= d_sel;
        cnt_r  <= cic_sel;
        acc    <= 1'b0;
      end
      if (run) begin
        cnt_r <= cnt_r - 1'b1;
        acc   <= acc | bus.cnt_RCO;
      end
      if (state == DONE) begin
        res_q   <= bus.cnt_Q;
        res_rco <= acc | bus.cnt_RCO;
      end
      if (state != IDLE && state_n == IDLE) begin
        gnt_r <= '0;
        last  <= gnt_r[1];
      end
    end
  end
endmodule

// File: tb/tb_cont_arbiter.sv
// tb_cont_arbiter: randomized self-checking bench with an external counter stand-in and a transaction-level reference model
module tb_cont_arbiter;
  import cont_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cont_arbiter_if #(.DW(4), .CW(4)) bus ();
  cont_arbiter #(.DW(4), .CW(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  int last_srv = 1;
  logic [3:0] q = 4'h0;
  logic rco = 1'b0;
  assign bus.cnt_Q = q;
  assign bus.cnt_RCO = rco;
  // shared 4-bit mode counter with registered RCO
  always @(posedge clk) begin
    if (!bus.cnt_enb) rco <= 1'b0;
    else case (bus.cnt_modo)
      MODO_UP:  begin rco <= q == 4'hF; q <= q + 4'd1; end
      MODO_DN:  begin rco <= q == 4'h0; q <= q - 4'd1; end
      MODO_DN3: begin rco <= q < 4'd3;  q <= q - 4'd3; end
      default:  begin rco <= 1'b0;      q <= bus.cnt_D; end
    endcase
  end
  // expected {enabled cycles, rco seen, final Q} for one run starting from counter value q0
  function automatic logic [9:0] model(input logic [3:0] q0, input logic [1:0] m, input logic [3:0] d, input int c);
    int n, v;
    bit w, pw, any;
    n = 0; v = q0; w = 0; pw = 0; any = 0;
    for (int i = 0; i < c; i++) begin
      n++;
      pw = w;
      case (m)
        2'd0: begin w = v == 15; v = (v + 1) % 16; end
        2'd1: begin w = v == 0; v = (v + 15) % 16; end
        2'd2: begin w = v < 3; v = (v + 13) % 16; end
        default: begin w = 0; v = d; end
      endcase
      any |= w;
`ifdef RCO_STOP_EN
      if (pw) break;
`endif
    end
    return {n[4:0], any, v[3:0]};
  endfunction
  task automatic txn(input int r, input logic [1:0] m, input logic [3:0] d, input logic [3:0] c,
                     output int t_gnt, output int t_done, output int n_enb, output int bad, output logic [1:0] g);
    t_gnt = 0; t_done = 0; n_enb = 0; bad = 0; g = 2'b00;
    if (r == 0) begin bus.req_modo0 = m; bus.req_D0 = d; bus.req_cic0 = c; end
    else begin bus.req_modo1 = m; bus.req_D1 = d; bus.req_cic1 = c; end
    bus.req[r] = 1'b1;
    for (int k = 1; k <= 40 && t_done == 0; k++) begin
      @(negedge clk);
      if (t_gnt == 0 && bus.gnt != 2'b00) begin
        t_gnt = k;
        g = bus.gnt;
        bus.req_modo0 = 2'($urandom); bus.req_D0 = 4'($urandom); bus.req_cic0 = 4'($urandom);
        bus.req_modo1 = 2'($urandom); bus.req_D1 = 4'($urandom); bus.req_cic1 = 4'($urandom);
      end
      if (bus.cnt_enb) begin
        n_enb++;
        if (bus.cnt_modo !== m || bus.cnt_D !== d) bad++;
      end
      if (bus.done) t_done = k;
    end
    bus.req[r] = 1'b0;
    last_srv = r;
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.req = 2'b00;
    bus.req_modo0 = 2'b00; bus.req_D0 = 4'h0; bus.req_cic0 = 4'h0;
    bus.req_modo1 = 2'b00; bus.req_D1 = 4'h0; bus.req_cic1 = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.gnt, bus.done, bus.busy, bus.cnt_enb} !== 5'b0) begin failures++; $display("FAIL reset_ctrl: got %b want 00000", {bus.gnt, bus.done, bus.busy, bus.cnt_enb}); end
    checks++; if ({bus.cnt_modo, bus.cnt_D} !== 6'b0) begin failures++; $display("FAIL reset_cnt_out: got %h want 0", {bus.cnt_modo, bus.cnt_D}); end
    checks++; if ({bus.res_Q, bus.res_rco} !== 5'b0) begin failures++; $display("FAIL reset_res: got %h want 0", {bus.res_Q, bus.res_rco}); end
    reset = 1'b0;
    last_srv = 1;
    @(negedge clk);
  endtask
  task automatic test_load();
    int tg, td, ne, bad; logic [1:0] g; logic [9:0] e;
    e = model(q, MODO_LD, 4'hA, 1);
    txn(0, MODO_LD, 4'hA, 4'd1, tg, td, ne, bad, g);
    checks++; if (g !== 2'b01 || tg !== 1) begin failures++; $display("FAIL load_gnt: got %b at %0d want 01 at 1", g, tg); end
    checks++; if (ne !== int'(e[9:5]) || bad !== 0) begin failures++; $display("FAIL load_enb: got %0d cycles (%0d bad) want %0d", ne, bad, e[9:5]); end
    checks++; if (td !== 2) begin failures++; $display("FAIL load_done: got cycle %0d want 2", td); end
    checks++; if (bus.res_Q !== e[3:0] || bus.res_rco !== e[4]) begin failures++; $display("FAIL load_res: got %h/%b want %h/%b", bus.res_Q, bus.res_rco, e[3:0], e[4]); end
    checks++; if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin failures++; $display("FAIL load_release: got gnt %b busy %b want 00 0", bus.gnt, bus.busy); end
  endtask
  task automatic test_up_wrap();
    int tg, td, ne, bad; logic [1:0] g; logic [9:0] e;
    txn(0, MODO_LD, 4'hE, 4'd1, tg, td, ne, bad, g);
    checks++; if (bus.res_Q !== 4'hE) begin failures++; $display("FAIL wrap_preload: got %h want e", bus.res_Q); end
    e = model(q, MODO_UP, 4'h0, 3);
    txn(0, MODO_UP, 4'h0, 4'd3, tg, td, ne, bad, g);
    checks++; if (bus.res_Q !== e[3:0] || bus.res_rco !== e[4]) begin failures++; $display("FAIL wrap_res: got %h/%b want %h/%b", bus.res_Q, bus.res_rco, e[3:0], e[4]); end
    checks++; if (ne !== int'(e[9:5]) || bad !== 0) begin failures++; $display("FAIL wrap_enb: got %0d cycles (%0d bad) want %0d", ne, bad, e[9:5]); end
    // latency counted inclusively from the request cycle to the done cycle
    checks++; if (td + 1 !== 5) begin failures++; $display("FAIL wrap_latency: got %0d want 5", td + 1); end
  endtask
  task automatic test_alternate();
    int nd, dk, en;
    logic [1:0] pg;
    nd = 0; dk = 0; pg = 2'b00;
    en = last_srv == 1 ? 0 : 1;
    bus.req_modo0 = MODO_UP; bus.req_D0 = 4'($urandom); bus.req_cic0 = 4'd2;
    bus.req_modo1 = MODO_UP; bus.req_D1 = 4'($urandom); bus.req_cic1 = 4'd2;
    bus.req = 2'b11;
    for (int k = 1; k <= 80 && nd < 4; k++) begin
      @(negedge clk);
      if (pg == 2'b00 && bus.gnt != 2'b00) begin
        checks++; if (bus.gnt !== 2'(1 << en)) begin failures++; $display("FAIL alt_order: got %b want %b", bus.gnt, 2'(1 << en)); end
        if (nd > 0) begin
          checks++; if (k - dk !== 2) begin failures++; $display("FAIL alt_gap: got %0d want 2", k - dk); end
        end
        last_srv = en;
        en ^= 1;
      end
      if (bus.done) begin
        dk = k;
        nd++;
        if (nd == 4) bus.req = 2'b00;
      end
      pg = bus.gnt;
    end
    checks++; if (nd !== 4) begin failures++; $display("FAIL alt_timeout: got %0d dones want 4", nd); end
    @(negedge clk);
  endtask
  task automatic test_abort();
    int n; bit sd; logic [3:0] rq; logic rr;
    rq = bus.res_Q; rr = bus.res_rco; n = 0; sd = 0;
    bus.req_modo1 = MODO_DN; bus.req_D1 = 4'($urandom); bus.req_cic1 = 4'd5;
    bus.req[1] = 1'b1;
    for (int k = 1; k <= 20 && n < 2; k++) begin
      @(negedge clk);
      if (bus.cnt_enb) n++;
    end
    bus.req[1] = 1'b0;
    checks++; if (n !== 2) begin failures++; $display("FAIL abort_timeout: got %0d run cycles want 2", n); end
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_release: got gnt %b busy %b want 00 0", bus.gnt, bus.busy); end
    repeat (4) begin
      if (bus.done) sd = 1;
      @(negedge clk);
    end
    checks++; if (sd !== 1'b0) begin failures++; $display("FAIL abort_done: got done pulse want none"); end
    checks++; if (bus.res_Q !== rq || bus.res_rco !== rr) begin failures++; $display("FAIL abort_res: got %h/%b want %h/%b", bus.res_Q, bus.res_rco, rq, rr); end
    last_srv = 1;
    bus.req_cic0 = 4'd4;
    bus.req = 2'b11;
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL abort_pointer: got %b want 01", bus.gnt); end
    bus.req = 2'b00;
    last_srv = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_mid_run();
    int tg, td, ne, bad, n; logic [1:0] g;
    txn(0, MODO_LD, 4'h9, 4'd1, tg, td, ne, bad, g);
    checks++; if (bus.res_Q !== 4'h9) begin failures++; $display("FAIL rst_preload: got %h want 9", bus.res_Q); end
    bus.req_modo0 = MODO_UP; bus.req_D0 = 4'h0; bus.req_cic0 = 4'd8;
    bus.req[0] = 1'b1;
    n = 0;
    for (int k = 1; k <= 20 && n < 3; k++) begin
      @(negedge clk);
      if (bus.cnt_enb) n++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({bus.cnt_enb, bus.gnt, bus.busy, bus.done} !== 5'b0) begin failures++; $display("FAIL rst_mid_ctrl: got %b want 00000", {bus.cnt_enb, bus.gnt, bus.busy, bus.done}); end
    checks++; if (bus.res_Q !== 4'h0 || bus.res_rco !== 1'b0) begin failures++; $display("FAIL rst_mid_res: got %h/%b want 0/0", bus.res_Q, bus.res_rco); end
    reset = 1'b0;
    bus.req_cic1 = 4'd4;
    bus.req = 2'b11;
    @(negedge clk);
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL rst_mid_pointer: got %b want 01", bus.gnt); end
    bus.req = 2'b00;
    last_srv = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_rco_stop();
    int tg, td, ne, bad; logic [1:0] g; logic [9:0] e;
    txn(0, MODO_LD, 4'h1, 4'd1, tg, td, ne, bad, g);
    e = model(q, MODO_DN3, 4'h0, 6);
    txn(1, MODO_DN3, 4'h0, 4'd6, tg, td, ne, bad, g);
    checks++; if (ne !== int'(e[9:5]) || td !== int'(e[9:5]) + 1) begin failures++; $display("FAIL rco_len: got %0d cycles done at %0d want %0d", ne, td, e[9:5]); end
    checks++; if (bus.res_rco !== 1'b1 || bus.res_Q !== e[3:0]) begin failures++; $display("FAIL rco_res: got %h/%b want %h/1", bus.res_Q, bus.res_rco, e[3:0]); end
  endtask
  task automatic test_random();
    int tg, td, ne, bad, r; logic [1:0] g, m; logic [3:0] d, c; logic [9:0] e;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 1));
      m = 2'($urandom);
      d = 4'($urandom);
      c = i == 0 ? 4'd0 : (i == 1 ? 4'hF : 4'($urandom));
      e = model(q, m, d, int'(c));
      txn(r, m, d, c, tg, td, ne, bad, g);
      checks++; if (g !== 2'(1 << r) || tg !== 1) begin failures++; $display("FAIL rnd_gnt[%0d]: got %b at %0d want %b at 1", i, g, tg, 2'(1 << r)); end
      checks++; if (ne !== int'(e[9:5]) || bad !== 0 || td !== int'(e[9:5]) + 1) begin failures++; $display("FAIL rnd_run[%0d]: got %0d cycles (%0d bad) done %0d want %0d", i, ne, bad, td, e[9:5]); end
      checks++; if (bus.res_Q !== e[3:0] || bus.res_rco !== e[4]) begin failures++; $display("FAIL rnd_res[%0d]: got %h/%b want %h/%b", i, bus.res_Q, bus.res_rco, e[3:0], e[4]); end
    end
  endtask
  initial begin
    bus.req = 2'b00;
    @(negedge clk);
    test_reset();
    test_load();
    test_up_wrap();
    test_alternate();
    test_abort();
    test_reset_mid_run();
    test_rco_stop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
